// File: rtl/pcie_phy_pkg.sv
// Shared 8b/10b ordered-set symbol constants and receiver state/type enums.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pcie_phy_pkg;

    localparam logic [7:0] SYM_COM    = 8'hBC;
    localparam logic [7:0] SYM_SKP    = 8'h1C;
    localparam logic [7:0] SYM_IDL    = 8'h7C;
    localparam logic [7:0] SYM_EIE    = 8'hFC;
    localparam logic [7:0] SYM_PAD    = 8'hF7;
    localparam logic [7:0] SYM_TS1_ID = 8'h4A;
    localparam logic [7:0] SYM_TS2_ID = 8'h45;
    localparam logic [7:0] SYM_D00    = 8'h00;

    // Consecutive-TS counter saturates here.
    localparam logic [7:0] CNT_MAX = 8'd255;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CLASSIFY,
        ST_TS,
        ST_EIEOS,
        ST_EIOS,
        ST_SKIP
    } os_lane_state_e;

    typedef enum logic [1:0] {
        OS_NONE,
        OS_TS1,
        OS_TS2
    } os_type_e;

endpackage

// File: rtl/os_rx_lane.sv
// One lane: byte-serial ordered-set framer/classifier with consecutive-TS and idle counters.
// Latency: flags/ts_o 1 cycle after the edge accepting the word holding the final symbol.
// Backpressure: none; invalid words are simply skipped and all state holds.
module os_rx_lane
    import pcie_phy_pkg::*;
#(
    parameter int LANE_WIDTH       = 32,
    parameter int TS_CONSEC_TARGET = 8,
    parameter int IDLE_TARGET      = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [LANE_WIDTH-1:0]   data_i,
    input  logic [LANE_WIDTH/8-1:0] data_k_i,
    input  logic                    data_valid_i,
    input  logic                    clear_cnt_i,
    output logic [127:0]            ts_o,
    output logic                    ts1_valid_o,
    output logic                    ts2_valid_o,
    output logic                    eieos_valid_o,
    output logic                    eios_valid_o,
    output logic                    skp_valid_o,
    output logic                    idle_valid_o,
    output logic                    ts1_consec_o,
    output logic                    ts2_consec_o,
    output logic                    idle_lvl_o
);

    localparam int NB = LANE_WIDTH / 8;

    os_lane_state_e   state_q, state_d;
    os_type_e         type_q, type_d, new_type;
    logic [3:0]       idx_q, idx_d;
    logic [15:1][7:0] buf_q, buf_d;
    logic [7:0]       idle_q, idle_d, cnt_q, cnt_d;
    logic [127:0]     ts_q, ts_d, new_ts;
    logic             ts1_q, ts1_d, ts2_q, ts2_d, eieos_q, eieos_d;
    logic             eios_q, eios_d, skp_q, skp_d, idlev_q, idlev_d;
    logic [7:0]       sym;
    logic             is_k, is_com, used;

    // Walk the word's bytes in order; every byte may advance framing and counters.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        idle_d  = idle_q;
        cnt_d   = cnt_q;
        ts_d    = ts_q;
        ts1_d   = 1'b0;
        ts2_d   = 1'b0;
        eieos_d = 1'b0;
        eios_d  = 1'b0;
        skp_d   = 1'b0;
        idlev_d = 1'b0;
        sym      = '0;
        is_k     = 1'b0;
        is_com   = 1'b0;
        used     = 1'b0;
        new_ts   = '0;
        new_type = OS_NONE;
        if (data_valid_i) begin
            for (int b = 0; b < NB; b++) begin
                sym    = data_i[8*b +: 8];
                is_k   = data_k_i[b];
                is_com = is_k && (sym == SYM_COM);
                used   = 1'b0;
                // SKIP runs first so the terminating symbol can fall through into HUNT.
                if (state_d == ST_SKIP) begin
                    if (is_k && sym == SYM_SKP) begin
                        used = 1'b1;
                        if (idx_d == 4'd5) state_d = ST_HUNT;
                        else               idx_d   = idx_d + 4'd1;
                    end else begin
                        skp_d   = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
                if (!used) begin
                    if (state_d == ST_HUNT) begin
                        if (is_com) begin
                            state_d = ST_CLASSIFY;
                            idx_d   = 4'd1;
                            idle_d  = '0;
                        end else if (!is_k && sym == SYM_D00) begin
                            if (idle_d < 8'(IDLE_TARGET)) begin
                                idle_d = idle_d + 8'd1;
                                if (idle_d == 8'(IDLE_TARGET)) idlev_d = 1'b1;
                            end
                        end else begin
                            idle_d = '0;
                        end
                    end else if (is_com) begin
                        state_d = ST_CLASSIFY;
                        idx_d   = 4'd1;
                    end else begin
                        case (state_d)
                            ST_CLASSIFY: begin
                                idx_d = 4'd2;
                                if (is_k && sym == SYM_IDL)      state_d = ST_EIOS;
                                else if (is_k && sym == SYM_SKP) begin
                                    state_d = ST_SKIP;
                                    idx_d   = 4'd1;
                                end
                                else if (is_k && sym == SYM_EIE) state_d = ST_EIEOS;
                                else if (!is_k || sym == SYM_PAD) begin
                                    state_d  = ST_TS;
                                    buf_d[1] = sym;
                                end
                                else                             state_d = ST_HUNT;
                            end
                            ST_TS: begin
                                buf_d[idx_d] = sym;
                                // Symbols 7..15 must be one repeated TS identifier.
                                if ((idx_d == 4'd7 && (is_k || (sym != SYM_TS1_ID && sym != SYM_TS2_ID))) ||
                                    (idx_d > 4'd7 && (is_k || sym != buf_d[7]))) begin
                                    state_d = ST_HUNT;
                                end else if (idx_d == 4'd15) begin
                                    state_d  = ST_HUNT;
                                    new_ts   = {buf_d, SYM_COM};
                                    new_type = (buf_d[7] == SYM_TS1_ID) ? OS_TS1 : OS_TS2;
                                    if (new_type == type_d && new_ts[47:8] == ts_d[47:8])
                                        cnt_d = (cnt_d == CNT_MAX) ? cnt_d : cnt_d + 8'd1;
                                    else
                                        cnt_d = 8'd1;
                                    type_d = new_type;
                                    ts_d   = new_ts;
                                    if (new_type == OS_TS1) ts1_d = 1'b1;
                                    else                    ts2_d = 1'b1;
                                end else begin
                                    idx_d = idx_d + 4'd1;
                                end
                            end
                            ST_EIEOS: begin
                                if (idx_d == 4'd15) begin
                                    if (!is_k && sym == SYM_TS1_ID) eieos_d = 1'b1;
                                    state_d = ST_HUNT;
                                end else if (is_k && sym == SYM_EIE) begin
                                    idx_d = idx_d + 4'd1;
                                end else begin
                                    state_d = ST_HUNT;
                                end
                            end
                            ST_EIOS: begin
                                if (is_k && sym == SYM_IDL) begin
                                    if (idx_d == 4'd3) begin
                                        eios_d  = 1'b1;
                                        cnt_d   = '0;
                                        idle_d  = '0;
                                        state_d = ST_HUNT;
                                    end else begin
                                        idx_d = idx_d + 4'd1;
                                    end
                                end else begin
                                    state_d = ST_HUNT;
                                end
                            end
                            default: state_d = ST_HUNT;
                        endcase
                    end
                end
            end
        end
        // Clear wins over any count change in the same word; flags and ts_o still update.
        if (clear_cnt_i) begin
            cnt_d  = '0;
            idle_d = '0;
        end
    end

    // State, counters, captured TS and one-cycle flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_HUNT;
            type_q  <= OS_NONE;
            idx_q   <= '0;
            buf_q   <= '0;
            idle_q  <= '0;
            cnt_q   <= '0;
            ts_q    <= '0;
            ts1_q   <= 1'b0;
            ts2_q   <= 1'b0;
            eieos_q <= 1'b0;
            eios_q  <= 1'b0;
            skp_q   <= 1'b0;
            idlev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            idle_q  <= idle_d;
            cnt_q   <= cnt_d;
            ts_q    <= ts_d;
            ts1_q   <= ts1_d;
            ts2_q   <= ts2_d;
            eieos_q <= eieos_d;
            eios_q  <= eios_d;
            skp_q   <= skp_d;
            idlev_q <= idlev_d;
        end
    end

    assign ts_o          = ts_q;
    assign ts1_valid_o   = ts1_q;
    assign ts2_valid_o   = ts2_q;
    assign eieos_valid_o = eieos_q;
    assign eios_valid_o  = eios_q;
    assign skp_valid_o   = skp_q;
    assign idle_valid_o  = idlev_q;
    assign ts1_consec_o  = (type_q == OS_TS1) && (cnt_q >= 8'(TS_CONSEC_TARGET));
    assign ts2_consec_o  = (type_q == OS_TS2) && (cnt_q >= 8'(TS_CONSEC_TARGET));
    assign idle_lvl_o    = (idle_q >= 8'(IDLE_TARGET));

endmodule

// File: rtl/os_rx_multilane.sv
// Multi-lane ordered-set receiver: per-lane decoders plus AND over enabled lanes.
// Latency: lane flags 1 cycle; all_* aggregates 1 cycle after per-lane levels.
// Backpressure: none; per-lane valid gaps just stall that lane's decoder.
module os_rx_multilane
    import pcie_phy_pkg::*;
#(
    parameter int NUM_LANES        = 4,
    parameter int LANE_WIDTH       = 32,
    parameter int TS_CONSEC_TARGET = 8,
    parameter int IDLE_TARGET      = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_LANES*LANE_WIDTH-1:0]   data_i,
    input  logic [NUM_LANES*LANE_WIDTH/8-1:0] data_k_i,
    input  logic [NUM_LANES-1:0]              data_valid_i,
    input  logic [NUM_LANES-1:0]              lane_en_i,
    input  logic                              clear_cnt_i,
    output logic [NUM_LANES*128-1:0]          ts_o,
    output logic [NUM_LANES-1:0]              ts1_valid_o,
    output logic [NUM_LANES-1:0]              ts2_valid_o,
    output logic [NUM_LANES-1:0]              eieos_valid_o,
    output logic [NUM_LANES-1:0]              eios_valid_o,
    output logic [NUM_LANES-1:0]              skp_valid_o,
    output logic [NUM_LANES-1:0]              idle_valid_o,
    output logic [NUM_LANES-1:0]              ts1_consec_o,
    output logic [NUM_LANES-1:0]              ts2_consec_o,
    output logic                              all_ts1_consec_o,
    output logic                              all_ts2_consec_o,
    output logic                              all_idle_o
);

    localparam int NB = LANE_WIDTH / 8;

    logic [NUM_LANES-1:0] idle_lvl;
    logic                 all_ts1_q, all_ts2_q, all_idle_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        os_rx_lane #(
            .LANE_WIDTH       (LANE_WIDTH),
            .TS_CONSEC_TARGET (TS_CONSEC_TARGET),
            .IDLE_TARGET      (IDLE_TARGET)
        ) u_lane (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .data_i        (data_i[g*LANE_WIDTH +: LANE_WIDTH]),
            .data_k_i      (data_k_i[g*NB +: NB]),
            .data_valid_i  (data_valid_i[g]),
            .clear_cnt_i   (clear_cnt_i),
            .ts_o          (ts_o[g*128 +: 128]),
            .ts1_valid_o   (ts1_valid_o[g]),
            .ts2_valid_o   (ts2_valid_o[g]),
            .eieos_valid_o (eieos_valid_o[g]),
            .eios_valid_o  (eios_valid_o[g]),
            .skp_valid_o   (skp_valid_o[g]),
            .idle_valid_o  (idle_valid_o[g]),
            .ts1_consec_o  (ts1_consec_o[g]),
            .ts2_consec_o  (ts2_consec_o[g]),
            .idle_lvl_o    (idle_lvl[g])
        );
    end

    // Disabled lanes are don't-care; an empty enable mask forces the aggregates low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            all_ts1_q  <= 1'b0;
            all_ts2_q  <= 1'b0;
            all_idle_q <= 1'b0;
        end else begin
            all_ts1_q  <= (lane_en_i != '0) && (&(ts1_consec_o | ~lane_en_i));
            all_ts2_q  <= (lane_en_i != '0) && (&(ts2_consec_o | ~lane_en_i));
            all_idle_q <= (lane_en_i != '0) && (&(idle_lvl     | ~lane_en_i));
        end
    end

    assign all_ts1_consec_o = all_ts1_q;
    assign all_ts2_consec_o = all_ts2_q;
    assign all_idle_o       = all_idle_q;

endmodule

// File: tb/tb_os_rx_multilane.sv
// Randomized ordered-set streams per lane, checked against an event-annotated reference model.
// Latency: expects flags one cycle after the accepting edge, aggregates one cycle later.
// Backpressure: random per-lane valid gaps exercise hold-state behaviour.
`timescale 1ns/1ps
module tb_os_rx_multilane;

    localparam int NL = 4, LW = 32, NB = 4, TGT = 8, ITGT = 8;
    localparam int E_TS = 1, E_EIE = 2, E_EIOS = 4, E_SKP = 8, E_IDLE = 16, E_START = 32;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic [NL*LW-1:0]   data_i;
    logic [NL*NB-1:0]   data_k_i;
    logic [NL-1:0]      data_valid_i, lane_en_i;
    logic               clear_cnt_i;
    logic [NL*128-1:0]  ts_o;
    logic [NL-1:0]      ts1_valid_o, ts2_valid_o, eieos_valid_o, eios_valid_o, skp_valid_o, idle_valid_o;
    logic [NL-1:0]      ts1_consec_o, ts2_consec_o;
    logic               all_ts1_consec_o, all_ts2_consec_o, all_idle_o;

    always #5 clk_i = ~clk_i;

    os_rx_multilane #(.NUM_LANES(NL), .LANE_WIDTH(LW), .TS_CONSEC_TARGET(TGT), .IDLE_TARGET(ITGT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .data_k_i(data_k_i),
        .data_valid_i(data_valid_i), .lane_en_i(lane_en_i), .clear_cnt_i(clear_cnt_i),
        .ts_o(ts_o), .ts1_valid_o(ts1_valid_o), .ts2_valid_o(ts2_valid_o),
        .eieos_valid_o(eieos_valid_o), .eios_valid_o(eios_valid_o), .skp_valid_o(skp_valid_o),
        .idle_valid_o(idle_valid_o), .ts1_consec_o(ts1_consec_o), .ts2_consec_o(ts2_consec_o),
        .all_ts1_consec_o(all_ts1_consec_o), .all_ts2_consec_o(all_ts2_consec_o), .all_idle_o(all_idle_o)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-lane symbol streams with the events each symbol is expected to trigger.
    logic [7:0]   qs  [NL][$];
    logic         qk  [NL][$];
    int           qe  [NL][$];
    logic [127:0] qts [NL][$];
    bit           pend_skp [NL];
    bit           ptrunc   [NL];
    logic [127:0] tmpl [3];

    // Reference model state per lane.
    int           m_cnt [NL], m_typ [NL], m_idle [NL];
    logic [127:0] m_last [NL];
    bit           lvl1 [NL], lvl2 [NL], lvli [NL];

    task automatic push(input int l, input logic [7:0] s, input logic k, input int e);
        int ee;
        ee = e;
        if (pend_skp[l]) begin
            ee = ee | E_SKP;
            pend_skp[l] = 1'b0;
        end
        qs[l].push_back(s);
        qk[l].push_back(k);
        qe[l].push_back(ee);
    endtask

    function automatic logic [127:0] rand_ts(input bit is1);
        logic [127:0] t;
        t[7:0]  = 8'hBC;
        t[15:8] = ($urandom_range(0, 1) == 1) ? 8'hF7 : 8'($urandom);
        for (int i = 2; i < 7; i++) t[8*i +: 8] = 8'($urandom);
        for (int i = 7; i < 16; i++) t[8*i +: 8] = is1 ? 8'h4A : 8'h45;
        return t;
    endfunction

    // trunc == 0 sends the full set; otherwise only symbols 1..trunc follow COM.
    task automatic push_ts(input int l, input logic [127:0] t, input int trunc);
        logic [7:0] s;
        push(l, 8'hBC, 1'b1, E_START);
        for (int i = 1; i < 16; i++) begin
            if (trunc != 0 && i > trunc) break;
            s = t[8*i +: 8];
            push(l, s, (i == 1 && s == 8'hF7), (i == 15) ? E_TS : 0);
        end
        if (trunc == 0) qts[l].push_back(t);
        ptrunc[l] = (trunc != 0);
    endtask

    task automatic push_eios(input int l);
        push(l, 8'hBC, 1'b1, E_START);
        push(l, 8'h7C, 1'b1, 0);
        push(l, 8'h7C, 1'b1, 0);
        push(l, 8'h7C, 1'b1, E_EIOS);
        ptrunc[l] = 1'b0;
    endtask

    task automatic rand_set(input int l);
        int r;
        r = $urandom_range(0, 99);
        if (r < 45) push_ts(l, tmpl[$urandom_range(0, 2)], 0);
        else if (r < 55) push_ts(l, rand_ts(r[0]), 0);
        else if (r < 65) begin
            push(l, 8'hBC, 1'b1, E_START);
            repeat ($urandom_range(1, 5)) push(l, 8'h1C, 1'b1, 0);
            pend_skp[l] = 1'b1;
            ptrunc[l] = 1'b0;
        end else if (r < 73) begin
            push(l, 8'hBC, 1'b1, E_START);
            repeat (14) push(l, 8'hFC, 1'b1, 0);
            push(l, 8'h4A, 1'b0, E_EIE);
            ptrunc[l] = 1'b0;
        end else if (r < 78) push_eios(l);
        else if (r < 88) push_ts(l, tmpl[$urandom_range(0, 2)], $urandom_range(1, 14));
        else if (!ptrunc[l]) repeat ($urandom_range(1, 12)) push(l, 8'h00, 1'b0, E_IDLE);
        else push_ts(l, tmpl[0], 0);
    endtask

    task automatic gen_lane(input int l);
        repeat (8) rand_set(l);
        repeat (20) push_ts(l, tmpl[0], 0);
        push_eios(l);
        repeat (20) push_ts(l, tmpl[2], 0);
        repeat (25) rand_set(l);
        push_eios(l);
        while (qs[l].size() % NB != 0) push(l, 8'h1C, 1'b1, 0);
    endtask

    // Consume one word for lane l and return the expected flag vector {idle,skp,eios,eieos,ts2,ts1}.
    task automatic model_word(input int l, output logic [5:0] p);
        int e, ty;
        logic [127:0] t;
        p = '0;
        for (int b = 0; b < NB; b++) begin
            e = qe[l].pop_front();
            void'(qs[l].pop_front());
            void'(qk[l].pop_front());
            if ((e & E_SKP) != 0) p[4] = 1'b1;
            if ((e & E_START) != 0) m_idle[l] = 0;
            if ((e & E_IDLE) != 0 && m_idle[l] < ITGT) begin
                m_idle[l]++;
                if (m_idle[l] == ITGT) p[5] = 1'b1;
            end
            if ((e & E_TS) != 0) begin
                t  = qts[l].pop_front();
                ty = (t[63:56] == 8'h4A) ? 1 : 2;
                if (ty == m_typ[l] && t[47:8] == m_last[l][47:8]) m_cnt[l] = (m_cnt[l] < 255) ? m_cnt[l] + 1 : 255;
                else m_cnt[l] = 1;
                m_typ[l]  = ty;
                m_last[l] = t;
                p[ty - 1] = 1'b1;
            end
            if ((e & E_EIE) != 0) p[2] = 1'b1;
            if ((e & E_EIOS) != 0) begin
                p[3] = 1'b1;
                m_cnt[l]  = 0;
                m_idle[l] = 0;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("%s ts_o L%0d", tag, l), ts_o[l*128 +: 128], '0);
            chk($sformatf("%s flags L%0d", tag, l),
                {idle_valid_o[l], skp_valid_o[l], eios_valid_o[l], eieos_valid_o[l], ts2_valid_o[l], ts1_valid_o[l],
                 ts2_consec_o[l], ts1_consec_o[l]}, '0);
        end
        chk($sformatf("%s agg", tag), {all_idle_o, all_ts2_consec_o, all_ts1_consec_o}, '0);
    endtask

    task automatic drive0(input logic [31:0] w, input logic [3:0] k);
        data_valid_i  = 4'b0001;
        data_i[31:0]  = w;
        data_k_i[3:0] = k;
    endtask

    logic [5:0]   exp_p [NL];
    bit           n1 [NL], n2 [NL], ni [NL];
    bit           a1, a2, ai, busy;
    logic [127:0] t0;
    logic [7:0]   sy;

    initial begin
        rst_ni = 1'b0; data_i = '0; data_k_i = '0; data_valid_i = '0; lane_en_i = 4'hF; clear_cnt_i = 1'b0;
        tmpl[0] = rand_ts(1'b1); tmpl[0][15:8] = 8'hF7;
        tmpl[1] = tmpl[0];       tmpl[1][15:8] = 8'h01;
        tmpl[2] = rand_ts(1'b0);
        for (int l = 0; l < NL; l++) begin
            pend_skp[l] = 0; ptrunc[l] = 0;
            m_cnt[l] = 0; m_typ[l] = 0; m_idle[l] = 0; m_last[l] = '0;
            lvl1[l] = 0; lvl2[l] = 0; lvli[l] = 0;
            gen_lane(l);
        end
        repeat (3) @(posedge clk_i);
        #1;
        check_zero("reset");
        rst_ni = 1'b1;

        for (int cyc = 0; cyc < 20000; cyc++) begin
            busy = 0;
            for (int l = 0; l < NL; l++) if (qs[l].size() != 0) busy = 1;
            if (!busy) break;
            clear_cnt_i = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) lane_en_i = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            for (int l = 0; l < NL; l++) begin
                exp_p[l] = '0;
                if (qs[l].size() >= NB && $urandom_range(0, 3) != 0) begin
                    data_valid_i[l] = 1'b1;
                    for (int b = 0; b < NB; b++) begin
                        data_i[l*LW + 8*b +: 8] = qs[l][b];
                        data_k_i[l*NB + b]      = qk[l][b];
                    end
                    model_word(l, exp_p[l]);
                end else begin
                    data_valid_i[l]       = 1'b0;
                    data_i[l*LW +: LW]    = LW'($urandom);
                    data_k_i[l*NB +: NB]  = NB'($urandom);
                end
                if (clear_cnt_i) begin
                    m_cnt[l]  = 0;
                    m_idle[l] = 0;
                end
                n1[l] = (m_typ[l] == 1) && (m_cnt[l] >= TGT);
                n2[l] = (m_typ[l] == 2) && (m_cnt[l] >= TGT);
                ni[l] = (m_idle[l] >= ITGT);
            end
            a1 = (lane_en_i != 0); a2 = a1; ai = a1;
            for (int l = 0; l < NL; l++) if (lane_en_i[l]) begin
                a1 = a1 & lvl1[l]; a2 = a2 & lvl2[l]; ai = ai & lvli[l];
            end
            @(posedge clk_i);
            #1;
            for (int l = 0; l < NL; l++) begin
                chk($sformatf("c%0d L%0d flags", cyc, l),
                    {idle_valid_o[l], skp_valid_o[l], eios_valid_o[l], eieos_valid_o[l], ts2_valid_o[l], ts1_valid_o[l]},
                    exp_p[l]);
                chk($sformatf("c%0d L%0d ts_o", cyc, l), ts_o[l*128 +: 128], m_last[l]);
                chk($sformatf("c%0d L%0d consec", cyc, l), {ts2_consec_o[l], ts1_consec_o[l]}, {n2[l], n1[l]});
                lvl1[l] = n1[l]; lvl2[l] = n2[l]; lvli[l] = ni[l];
            end
            chk($sformatf("c%0d agg", cyc), {all_idle_o, all_ts2_consec_o, all_ts1_consec_o}, {ai, a2, a1});
        end
        busy = 0;
        for (int l = 0; l < NL; l++) if (qs[l].size() != 0) busy = 1;
        chk("stream drained", busy, 1'b0);

        // Reset mid-TS: partial state must be dropped and outputs cleared at once.
        clear_cnt_i = 1'b0; lane_en_i = 4'hF;
        t0 = 128'h0;
        t0[7:0] = 8'hBC; t0[15:8] = 8'hF7; t0[23:16] = 8'h11; t0[31:24] = 8'h22;
        t0[39:32] = 8'h33; t0[47:40] = 8'h44; t0[55:48] = 8'h55;
        for (int i = 7; i < 16; i++) t0[8*i +: 8] = 8'h4A;
        drive0(t0[31:0], 4'b0011);
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1 check_zero("async rst");
        data_valid_i = '0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int w = 1; w < 4; w++) begin
            drive0(t0[32*w +: 32], 4'b0000);
            @(posedge clk_i);
            #1 chk($sformatf("post-rst w%0d ts1", w), ts1_valid_o[0], 1'b0);
        end
        for (int w = 0; w < 4; w++) begin
            drive0(t0[32*w +: 32], (w == 0) ? 4'b0011 : 4'b0000);
            @(posedge clk_i);
            #1 chk($sformatf("full ts1 w%0d", w), ts1_valid_o[0], (w == 3));
        end
        data_valid_i = '0;
        chk("full ts1 ts_o", ts_o[127:0], t0);
        sy = ts_o[15:8];
        chk("full ts1 sym1", sy, 8'hF7);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/os_rx_multilane.md
# os_rx_multilane

Parametrised multi-lane 8b/10b (Gen1/Gen2) ordered-set receiver between the per-lane PIPE RX datapath and the LTSSM. Each lane runs an independent byte-serial decoder that frames and classifies TS1, TS2, EIEOS, EIOS, SKP and logical idle. It also tracks consecutive identical training sets per lane. A top-level stage ANDs per-lane status over the enabled lanes so the LTSSM can apply its "N consecutive TS on all lanes" exit conditions directly.

## Interface
- NUM_LANES, 4, lanes instantiated; legal values 1, 2, 4, 8, 16
- LANE_WIDTH, 32, bits per lane per cycle; legal values 8, 16, 32
- TS_CONSEC_TARGET, 8, consecutive identical TS needed to assert a consec flag; range 1..255
- IDLE_TARGET, 8, consecutive D0.0 symbols needed for idle_valid_o
- clk_i  in  1  sole clock
- rst_ni  in  1  asynchronous, active-low reset
- data_i  in  NUM_LANES*LANE_WIDTH  lane n occupies slice n; byte 0 of a slice is the earliest symbol
- data_k_i  in  NUM_LANES*LANE_WIDTH/8  K flag per byte
- data_valid_i  in  NUM_LANES  per-lane word valid
- lane_en_i  in  NUM_LANES  lanes included in aggregation
- clear_cnt_i  in  1  synchronous clear of all consecutive and idle counters
- ts_o  out  NUM_LANES*128  last accepted TS per lane; symbol 0 in bits [7:0]
- ts1_valid_o, ts2_valid_o, eieos_valid_o, eios_valid_o, skp_valid_o, idle_valid_o  out  NUM_LANES each  one-cycle pulses
- ts1_consec_o, ts2_consec_o  out  NUM_LANES  level; count >= TS_CONSEC_TARGET
- all_ts1_consec_o, all_ts2_consec_o, all_idle_o  out  1  AND over enabled lanes; 0 when lane_en_i == 0

## Operation
- Symbols: COM=BC(K), SKP=1C(K), IDL=7C(K), EIE=FC(K), PAD=F7(K), TS1 ID=4A(D), TS2 ID=45(D), D0.0=00(D).
- Each valid word is processed byte by byte (byte 0 first) through the per-lane FSM. An invalid word leaves all state unchanged; gaps are legal mid-set.
- HUNT:
  - On COM, go to CLASSIFY with sym_idx=1.
  - A D0.0 symbol increments idle_cnt. Any other symbol clears idle_cnt.
  - idle_valid pulses when idle_cnt reaches IDLE_TARGET; the counter then saturates.
- CLASSIFY looks at symbol 1:
  - IDL goes to EIOS.
  - SKP goes to SKIP.
  - EIE goes to EIEOS.
  - D symbol or PAD goes to TS.
  - Any other symbol goes to HUNT.
- TS: store symbols 1..15. At symbol 15, symbols 7..15 must all equal 4A (TS1) or all equal 45 (TS2). Otherwise discard silently.
- EIEOS: symbols 1..14 must be EIE(K) and symbol 15 must be 4A(D).
- EIOS: symbols 1..3 must all be IDL.
- SKIP:
  - Accept 1..5 SKP symbols.
  - The first non-SKP symbol completes the set (skp_valid) and is reprocessed in HUNT (COM restarts framing).
  - A 6th SKP aborts to HUNT.
- In any non-HUNT state:
  - COM restarts at CLASSIFY, abandoning the current set.
  - Any symbol violating the rules above returns to HUNT without a flag.
- Consecutive tracking on each accepted TS:
  - If its type and symbols 1..5 match the previously accepted TS, cnt = min(cnt+1, 255).
  - Otherwise cnt=1 and the type is recorded.
  - ts_o is updated with the new TS.
- EIOS, clear_cnt_i, or reset: cnt=0, idle_cnt=0.
- Multiple completions in one word: flags are ORed into the word's pulse. At most one TS/EIEOS can complete per word; for a TS, the last completion wins in ts_o.

## Timing
- Reset values:
  - All pulse and level outputs: 0.
  - ts_o: 0.
  - FSM: HUNT.
  - Counters: 0.
- Latency: a pulse is asserted in the cycle after the clock edge that accepts the word containing the final symbol (1 cycle).
- ts_o changes in the same cycle as its ts1/ts2 pulse.
- Consec levels update together with the TS pulse. They drop to 0 one cycle after clear_cnt_i, an EIOS, or a mismatching TS.
- Aggregate outputs are registered: one cycle after the per-lane levels.
- clear_cnt_i takes priority over a TS completing in the same word: the counter ends at 0, and the TS pulse and ts_o update still occur.
- Reset mid-set discards partial state immediately; there is no pulse.

## Structure
- pcie_phy_pkg holds:
  - the symbol constants above;
  - os_lane_state_e (HUNT, CLASSIFY, TS, EIEOS, EIOS, SKIP);
  - os_type_e (NONE, TS1, TS2).
- Sub-module os_rx_lane: one lane's FSM, counters and ts_o storage. The top generates NUM_LANES instances and performs the aggregation.

## Test plan
- Lane 0, LANE_WIDTH=32: COM,PAD,PAD,... + 4A×10 over 4 words, 8 times -> ts1_valid_o[0] pulses 8×; ts1_consec_o[0] rises with the 8th pulse.
- 8 identical TS2 on lanes 0..3, lane_en_i=4'b1111 -> all_ts2_consec_o=1 one cycle after the last lane's consec flag; with lane 2 sending TS1, all_ts2_consec_o stays 0.
- TS1 sequence with the 5th TS having symbol 1 changed from PAD to 01 -> cnt resets to 1; ts1_consec_o requires 7 more identical TS.
- Word BC,1C,1C,BC followed by 4A,... (TS1 start) -> skp_valid_o pulses once; the TS1 completes normally.
- COM,IDL,IDL,IDL after 5 TS1 -> eios_valid_o pulse, cnt=0; COM + 14 EIE + 4A -> eieos_valid_o pulse.
- COM injected at symbol 9 of a TS1 -> no ts1 pulse; the set restarts and the following 15 valid symbols produce one ts1_valid_o pulse. rst_ni asserted mid-TS -> all outputs 0 asynchronously.
